// File: rtl/vend_pkg.sv
// vend_pkg: channel indices (index order is arbitration priority) and debounce defaults.
package vend_pkg;
    localparam int CH_DIME        = 0;
    localparam int CH_NICKEL      = 1;
    localparam int CH_DISPENSE    = 2;
    localparam int NUM_CH         = 3;
    localparam int DEBOUNCE_SIM   = 3;
    localparam int DEBOUNCE_BOARD = 1_000_000;
endpackage

// File: rtl/coin_input_conditioner_if.sv
// coin_input_conditioner_if: raw board inputs in, clean event pulses out.
interface coin_input_conditioner_if;
    logic nickel_raw;
    logic dime_raw;
    logic dispense_raw;
    logic nickel_pulse;
    logic dime_pulse;
    logic dispense_pulse;
    logic pending;
    modport master (
        output nickel_raw, dime_raw, dispense_raw,
        input  nickel_pulse, dime_pulse, dispense_pulse, pending
    );
    modport slave (
        input  nickel_raw, dime_raw, dispense_raw,
        output nickel_pulse, dime_pulse, dispense_pulse, pending
    );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF sync, hold-for-N-cycles debounce, rising-edge detect.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, stable, stable_d;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, stable, stable_d} <= '0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            stable_d <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
    assign rise = stable & ~stable_d;
endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: three conditioned channels queued into a fixed-priority
// one-pulse-per-cycle arbiter (dime > nickel > dispense).
module coin_input_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input logic clk,
    input logic rst,
    coin_input_conditioner_if.slave bus
);
    logic [NUM_CH-1:0] raw, rise, flags, req, grant, pulse_q;
    logic pending_q;
    assign raw[CH_DIME]     = bus.dime_raw;
    assign raw[CH_NICKEL]   = bus.nickel_raw;
    assign raw[CH_DISPENSE] = bus.dispense_raw;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[c]),
            .rise (rise[c])
        );
    end
    // A rise may be granted in the cycle it arrives; lowest index set wins.
    always_comb begin
        req   = flags | rise;
        grant = req & (~req + NUM_CH'(1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            flags     <= '0;
            pulse_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            flags     <= req & ~grant;
            pulse_q   <= grant;
            pending_q <= |(req & ~grant);
        end
    end
    assign bus.dime_pulse     = pulse_q[CH_DIME];
    assign bus.nickel_pulse   = pulse_q[CH_NICKEL];
    assign bus.dispense_pulse = pulse_q[CH_DISPENSE];
    assign bus.pending        = pending_q;
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed scenarios plus random stimulus checked against
// a sliding-window debounce and priority-queue reference model.
`timescale 1ns/1ps
module tb_coin_input_conditioner;
    import vend_pkg::*;
    localparam int D = DEBOUNCE_SIM;
    logic clk = 1'b0;
    logic rst = 1'b1;
    coin_input_conditioner_if bus();
    coin_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #1 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    bit hist [NUM_CH][D+1];
    logic [NUM_CH-1:0] m_stable, m_stable_d, m_flags, exp_pulse;
    logic exp_pend;
    int t;
    int count [NUM_CH];
    int first [NUM_CH];
    // Stable level flips once the D synchronised samples before the newest all agree.
    task automatic model_edge(input logic [NUM_CH-1:0] r, input logic rv);
        logic [NUM_CH-1:0] q, g;
        bit same;
        if (rv) begin
            m_stable = '0; m_stable_d = '0; m_flags = '0; exp_pulse = '0; exp_pend = 1'b0;
            foreach (hist[c, k]) hist[c][k] = 1'b0;
            return;
        end
        q = m_flags | (m_stable & ~m_stable_d);
        g = '0;
        for (int c = 0; c < NUM_CH; c++) if (q[c]) begin g[c] = 1'b1; break; end
        exp_pulse = g;
        m_flags = q & ~g;
        exp_pend = |m_flags;
        m_stable_d = m_stable;
        for (int c = 0; c < NUM_CH; c++) begin
            same = 1'b1;
            for (int k = 1; k < D; k++) if (hist[c][k] != hist[c][0]) same = 1'b0;
            if (same && hist[c][0] != m_stable[c]) m_stable[c] = hist[c][0];
            for (int k = 0; k < D; k++) hist[c][k] = hist[c][k+1];
            hist[c][D] = r[c];
        end
    endtask
    task automatic step(input logic [NUM_CH-1:0] r, input logic rv);
        logic [NUM_CH-1:0] obs;
        bus.dime_raw = r[CH_DIME];
        bus.nickel_raw = r[CH_NICKEL];
        bus.dispense_raw = r[CH_DISPENSE];
        rst = rv;
        @(posedge clk);
        model_edge(r, rv);
        #0.5;
        t++;
        obs[CH_DIME] = bus.dime_pulse;
        obs[CH_NICKEL] = bus.nickel_pulse;
        obs[CH_DISPENSE] = bus.dispense_pulse;
        vectors += 3;
        assert (obs === exp_pulse) else begin
            miscompares++;
            $error("FAIL pulses t=%0d observed=%b expected=%b", t, obs, exp_pulse);
        end
        assert (bus.pending === exp_pend) else begin
            miscompares++;
            $error("FAIL pending t=%0d observed=%b expected=%b", t, bus.pending, exp_pend);
        end
        assert ($onehot0(obs)) else begin
            miscompares++;
            $error("FAIL exclusive t=%0d observed=%b expected=at most one bit", t, obs);
        end
        for (int c = 0; c < NUM_CH; c++) if (obs[c] === 1'b1) begin
            count[c]++;
            if (first[c] < 0) first[c] = t;
        end
    endtask
    task automatic phase_start();
        t = 0;
        for (int c = 0; c < NUM_CH; c++) begin count[c] = 0; first[c] = -1; end
    endtask
    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask
    task automatic hold(input logic [NUM_CH-1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask
    initial begin
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] dime_only, nickel_only, disp_only;
        dime_only = '0; dime_only[CH_DIME] = 1'b1;
        nickel_only = '0; nickel_only[CH_NICKEL] = 1'b1;
        disp_only = '0; disp_only[CH_DISPENSE] = 1'b1;
        // reset held with all inputs high, then released
        phase_start();
        for (int i = 0; i < 5; i++) step('1, 1'b1);
        check("reset_quiet", count[0] + count[1] + count[2], 0);
        phase_start();
        hold('1, 4);
        hold('0, 12);
        check("rel_dime_cnt", count[CH_DIME], 1);
        check("rel_nickel_cnt", count[CH_NICKEL], 1);
        check("rel_disp_cnt", count[CH_DISPENSE], 1);
        check("rel_dime_t", first[CH_DIME], D + 3);
        check("rel_nickel_t", first[CH_NICKEL], D + 4);
        check("rel_disp_t", first[CH_DISPENSE], D + 5);
        // clean nickel
        phase_start();
        hold(nickel_only, 5);
        hold('0, 10);
        check("nickel_cnt", count[CH_NICKEL], 1);
        check("nickel_latency", first[CH_NICKEL], D + 3);
        check("nickel_others", count[CH_DIME] + count[CH_DISPENSE], 0);
        // bouncing dime
        phase_start();
        hold(dime_only, 1); hold('0, 1); hold(dime_only, 1); hold('0, 1);
        hold(dime_only, 8);
        hold('0, 10);
        check("bounce_cnt", count[CH_DIME], 1);
        check("bounce_latency", first[CH_DIME], 4 + D + 3);
        // short dispense glitch
        phase_start();
        hold(disp_only, 2);
        hold('0, 10);
        check("glitch_cnt", count[CH_DISPENSE], 0);
        check("glitch_cnt_reg", int'(dut.g_ch[2].u_ch.cnt), 0);
        // three-way collision
        phase_start();
        hold('1, 6);
        hold('0, 12);
        check("coll_dime_t", first[CH_DIME], D + 3);
        check("coll_nickel_t", first[CH_NICKEL], D + 4);
        check("coll_disp_t", first[CH_DISPENSE], D + 5);
        check("coll_total", count[0] + count[1] + count[2], 3);
        // held dime, repeat press, then reset mid-count
        phase_start();
        hold(dime_only, 20);
        check("held_cnt", count[CH_DIME], 1);
        hold('0, 5);
        hold(dime_only, 5);
        hold('0, 10);
        check("repeat_cnt", count[CH_DIME], 2);
        phase_start();
        hold(dime_only, 3);
        step('0, 1'b1);
        hold('0, 10);
        check("reset_midcount", count[CH_DIME], 0);
        // random stimulus with occasional resets
        r = '0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NUM_CH; c++) if ($urandom_range(5) == 0) r[c] = ~r[c];
            step(r, $urandom_range(60) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
